// File: rtl/cgu_serial_adder_if.sv
// Handshake and operand/result bundle for the two-bit-per-cycle CGU serial adder.
// The requester drives the master side; the adder implements the slave side.
interface cgu_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cgu_serial_adder.sv
// Sequential adder that resolves one operand bit pair per cycle using the
// 2-bit carry generation unit equations, with a start/busy/done handshake.
module cgu_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cgu_serial_adder_if.slave    bus
);
    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             p0, g0, p1, g1, c0, c1, s0, s1;
    logic [WIDTH-1:0] pair_w;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right two bits per RUN cycle, so the current pair is
    // always at bits [1:0]; the sum pair enters the accumulator from the top.
    always_comb begin
        p0 = a_q[0] ^ b_q[0];
        g0 = a_q[0] & b_q[0];
        p1 = a_q[1] ^ b_q[1];
        g1 = a_q[1] & b_q[1];
        c0 = g0 | (p0 & carry_q);
        c1 = g1 | (p1 & g0) | (p1 & p0 & carry_q);
        s0 = p0 ^ carry_q;
        s1 = p1 ^ c0;
        pair_w      = '0;
        pair_w[1:0] = {s1, s0};
        acc_next    = (acc_q >> 2) | (pair_w << (WIDTH - 2));
    end

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 2;
                b_d     = b_q >> 2;
                acc_d   = acc_next;
                carry_d = c1;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    sum_d   = acc_next;
                    cout_d  = c1;
                    ovf_d   = c0 ^ c1;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cgu_serial_adder.sv
// Directed bench for cgu_serial_adder: expected results are queued when a
// request is driven and popped when the done pulse appears.
module tb_cgu_serial_adder;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    exp_t sb[$];
    logic [WIDTH-1:0] prev_sum;

    cgu_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    cgu_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        exp_t        e;
        logic [WIDTH:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Called on a falling edge: raise start for one rising edge, then scramble
    // the operand inputs to show the latched copies are what get added.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        sb.push_back(model(a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~cin;
    endtask

    // Starts in the first cycle after acceptance; ends in the done cycle.
    task automatic wait_result(input string tag, input bit inject_start);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            chk({tag, "_busy"}, bus.busy, 1'b1);
            chk({tag, "_hold"}, bus.sum, prev_sum);
            if (inject_start && cyc == 1) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
            end
            @(negedge clk);
            if (inject_start && cyc == 1) bus.start = 1'b0;
            cyc++;
        end
        chk({tag, "_done_seen"}, bus.done, 1'b1);
        chk({tag, "_latency"}, cyc, N);
        chk({tag, "_busy_in_done"}, bus.busy, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, bus.sum, e.sum);
            chk({tag, "_cout"}, bus.cout, e.cout);
            chk({tag, "_ovf"}, bus.ovf, e.ovf);
            prev_sum = e.sum;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin);
        drive_start(a, b, cin);
        wait_result(tag, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        prev_sum  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sum",  bus.sum,  8'h00);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf",  bus.ovf,  1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_op("zero",      8'h00, 8'h00, 1'b0);
        run_op("ripple",    8'hFF, 8'h01, 1'b0);
        run_op("pos_ovf",   8'h7F, 8'h01, 1'b0);
        run_op("neg_ovf",   8'h80, 8'h80, 1'b0);
        run_op("all_prop",  8'hAA, 8'h55, 1'b1);
        run_op("mixed",     8'h5C, 8'hB7, 1'b1);

        // Start during RUN is ignored; start in the DONE cycle chains directly.
        drive_start(8'h12, 8'h34, 1'b0);
        wait_result("busy_ign", 1'b1);
        drive_start(8'h01, 8'h01, 1'b0);
        wait_result("b2b", 1'b0);
        @(negedge clk);
        chk("b2b_done_pulse", bus.done, 1'b0);

        // Reset in the second RUN cycle aborts the operation.
        drive_start(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_sum",  bus.sum,  8'h00);
        chk("abort_cout", bus.cout, 1'b0);
        chk("abort_ovf",  bus.ovf,  1'b0);
        @(negedge clk);
        chk("rst_start_ign", bus.busy, 1'b0);
        bus.start = 1'b0;
        rst       = 1'b0;
        prev_sum  = '0;
        repeat (N + 2) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 1'b0);
        end
        chk("abort_sb_empty", sb.size(), 0);

        run_op("post_rst", 8'h03, 8'h05, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
